axi_ddr_responder: RTL and testbench
====================================

Name: axi_ddr_responder

Overview:
- AXI4 slave responder with on-chip RAM. It sits at the far end of the system's DDR AXI master port and stands in for the MIG/DDR controller in simulation and in FPGA builds that have no DDR.
- Accepts independent read and write bursts and returns OKAY/SLVERR responses.
- Interface widths match the system AXI master: 1-bit IDs, 8-bit burst length, MIG-bus data width.

Parameters:
- ADDR_W, 30: AXI address width; equals DDR_ADDR_W.
- DATA_W, 32: AXI data width; equals MIG_BUS_W. Legal values: 32, 64, 128, 256.
- MEM_ADDR_W, 16: log2 of RAM depth in DATA_W-wide words.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- s_axi_awid  input  1  write ID
- s_axi_awaddr  input  ADDR_W  write burst start byte address
- s_axi_awlen  input  8  beats minus 1
- s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos  input  3,2,1,4,3,4  accepted and ignored
- s_axi_awvalid  input  1 / s_axi_awready  output  1  AW handshake
- s_axi_wdata  input  DATA_W / s_axi_wstrb  input  DATA_W/8 / s_axi_wlast  input  1  write beat
- s_axi_wvalid  input  1 / s_axi_wready  output  1  W handshake
- s_axi_bid  output  1 / s_axi_bresp  output  2 / s_axi_bvalid  output  1 / s_axi_bready  input  1  write response
- s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos  input  same widths as AW  read address
- s_axi_arvalid  input  1 / s_axi_arready  output  1  AR handshake
- s_axi_rid  output  1 / s_axi_rdata  output  DATA_W / s_axi_rresp  output  2 / s_axi_rlast  output  1  read beat
- s_axi_rvalid  output  1 / s_axi_rready  input  1  R handshake

Behaviour:
- Reset: rst_n low clears both FSMs to IDLE immediately. Output values during reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0. RAM contents are not reset.
- Reset mid-burst: the burst is abandoned. No response is issued after reset release. Partially written RAM words keep the values already written.
- Word index = addr[MEM_ADDR_W+log2(DATA_W/8)-1 : log2(DATA_W/8)]. High bits are dropped, so addresses alias modulo the RAM size.
- Address generation: every burst type is treated as INCR. The word index increments by 1 per beat and wraps from 2^MEM_ADDR_W-1 to 0. awsize and arsize are ignored; every beat is full width.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id, word index and len; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb to RAM in that cycle. After beat awlen+1, go to W_RESP.
  - W_RESP: bvalid=1 and bid=latched ID. Hold until bready, then return to W_IDLE.
  - bresp=2'b10 (SLVERR) if wlast was high on any beat other than the last, or low on the last beat. Otherwise 2'b00. Data is written in both cases.
- Write throughput: 1 beat/cycle. Next AW is accepted no earlier than the cycle after the B handshake.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake in cycle T, latch id, word index and len; the RAM read is issued in T+1.
  - First rvalid is asserted in T+2.
  - R_DATA: rdata, rlast and rid stay stable while rvalid=1 and rready=0. A one-entry prefetch/skid buffer sustains 1 beat/cycle while rready is held high.
  - rlast=1 on beat arlen+1. After that handshake, return to R_IDLE.
  - rresp is always 2'b00.
- Read and write channels are fully independent and may be active in the same cycle.
- Same-word collision (read and write in one cycle): the read returns the pre-write data (read-first). The collision is resolved beat by beat.
- W beats arriving before the AW handshake are not accepted (wready=0 in W_IDLE).
- arlen=0 and awlen=0 are single-beat bursts. arlen=255 gives a 256-beat burst with word-index wrap allowed inside the burst.

Test Plan:
- Single write then read: AW addr 0x100, awlen 0, wdata 0xDEADBEEF, wstrb 0xF -> bresp 0, bid echoed; AR addr 0x100 -> rdata 0xDEADBEEF, rlast=1, first rvalid 2 cycles after AR handshake.
- 16-beat bursts: write pattern i at addr 0x0, beats back-to-back -> one B; read with rready=1 -> 16 consecutive rvalid cycles, rlast only on beat 16, data 0..15.
- Backpressure: rready toggled pseudo-randomly during a 256-beat read -> no beat lost or duplicated, rdata stable while stalled; bready held low 10 cycles -> bvalid stays high and no new AW is accepted.
- Byte strobes and wlast errors:
  - Write 0xFFFFFFFF, then 0x00000000 with wstrb 0x5 -> read returns 0xFF00FF00.
  - 4-beat burst with wlast on beat 2 -> bresp 2'b10.
- Wrap and concurrency: burst starting at the last word with len 1 -> second beat hits word 0; simultaneous read and write of the same word -> read returns old data.
- Reset mid-burst: assert rst_n low during beat 3 of an 8-beat read -> rvalid=0 at once, arready=1 after release, no stray B/R beats.

Source files
------------

// File: rtl/axi_ddr_responder.sv
// AXI4 slave backed by an on-chip RAM; stands in for the DDR controller
// in simulation and in FPGA builds without external memory.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axi_aw*             write address channel (size/burst/lock/cache/prot/qos ignored)
//   s_axi_w*              write data channel, byte strobes honoured
//   s_axi_b*              write response (SLVERR on wlast misplacement)
//   s_axi_ar*             read address channel (size/burst/lock/cache/prot/qos ignored)
//   s_axi_r*              read data channel, rresp always OKAY
//
// All bursts are INCR with full-width beats. The word index wraps modulo
// the RAM depth. Reads are read-first against a same-cycle write.
module axi_ddr_responder #(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  // write address
  input  logic                s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic [3:0]          s_axi_awqos,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  // write data
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  // write response
  output logic                s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  // read address
  input  logic                s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic [3:0]          s_axi_arqos,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  // read data
  output logic                s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned DEPTH  = 1 << MEM_ADDR_W;
  localparam int unsigned LEN_W  = 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------- write
  w_state_t              r_wstate;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic                  r_bid;
  logic [1:0]            r_bresp;
  logic                  r_wid;
  logic [MEM_ADDR_W-1:0] r_waddr;
  logic [LEN_W-1:0]      r_wlen;
  logic [LEN_W-1:0]      r_wcnt;
  logic                  r_werr;

  logic w_aw_fire;
  logic w_w_fire;
  logic w_w_last;

  assign w_aw_fire = s_axi_awvalid & r_awready;
  assign w_w_fire  = s_axi_wvalid & r_wready;
  assign w_w_last  = (r_wcnt == r_wlen);

  // Write FSM: address latch, beat counting, wlast checking, response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= 1'b0;
      r_bresp   <= 2'b00;
      r_wid     <= 1'b0;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_fire) begin
            r_wid     <= s_axi_awid;
            r_waddr   <= s_axi_awaddr[MEM_ADDR_W+OFF_W-1:OFF_W];
            r_wlen    <= s_axi_awlen;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_fire) begin
            r_waddr <= r_waddr + MEM_ADDR_W'(1);
            r_wcnt  <= r_wcnt + LEN_W'(1);
            if (w_w_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_wid;
              r_bresp  <= (r_werr | ~s_axi_wlast) ? 2'b10 : 2'b00;
              r_wstate <= W_RESP;
            end else if (s_axi_wlast) begin
              r_werr <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // RAM byte-enable write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_w_fire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) r_mem[r_waddr][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_t              r_rstate;
  logic                  r_arready;
  logic                  r_rid;
  logic [MEM_ADDR_W-1:0] r_raddr;
  logic [LEN_W-1:0]      r_rcnt;
  logic                  r_fetch;
  logic                  r_rvalid;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_rlast;
  logic                  r_skid_vld;
  logic [DATA_W-1:0]     r_skid_data;
  logic                  r_skid_last;

  logic w_ar_fire;
  logic w_r_fire;
  logic w_issue;
  logic w_issue_last;
  logic w_out_free;

  assign w_ar_fire    = s_axi_arvalid & r_arready;
  assign w_r_fire     = r_rvalid & s_axi_rready;
  // Only fetch while the skid slot is free, so a fetched word always has a home
  assign w_issue      = r_fetch & ~r_skid_vld;
  assign w_issue_last = (r_rcnt == '0);
  assign w_out_free   = ~r_rvalid | w_r_fire;

  // Read FSM with RAM fetch, output register and one-entry skid buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate    <= R_IDLE;
      r_arready   <= 1'b1;
      r_rid       <= 1'b0;
      r_raddr     <= '0;
      r_rcnt      <= '0;
      r_fetch     <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_rlast     <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_skid_last <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_fire) begin
            r_rid     <= s_axi_arid;
            r_raddr   <= s_axi_araddr[MEM_ADDR_W+OFF_W-1:OFF_W];
            r_rcnt    <= s_axi_arlen;
            r_fetch   <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_fire && r_rlast) begin
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase

      // fetch pointer and remaining-beat count
      if (w_issue) begin
        r_raddr <= r_raddr + MEM_ADDR_W'(1);
        r_rcnt  <= r_rcnt - LEN_W'(1);
        if (w_issue_last) r_fetch <= 1'b0;
      end

      // fetched word goes to the output if it frees up this cycle, else to skid
      if (w_issue && w_out_free) begin
        r_rdata  <= r_mem[r_raddr];
        r_rlast  <= w_issue_last;
        r_rvalid <= 1'b1;
      end else if (w_issue) begin
        r_skid_data <= r_mem[r_raddr];
        r_skid_last <= w_issue_last;
        r_skid_vld  <= 1'b1;
      end else if (r_skid_vld && w_r_fire) begin
        r_rdata    <= r_skid_data;
        r_rlast    <= r_skid_last;
        r_skid_vld <= 1'b0;
      end else if (w_r_fire) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rid     = r_rid;
  assign s_axi_rresp   = 2'b00;

  // Sideband fields and address bits outside the RAM window are ignored
  logic w_unused;
  assign w_unused = ^{s_axi_awaddr[ADDR_W-1:MEM_ADDR_W+OFF_W], s_axi_awaddr[OFF_W-1:0],
                      s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache,
                      s_axi_awprot, s_axi_awqos,
                      s_axi_araddr[ADDR_W-1:MEM_ADDR_W+OFF_W], s_axi_araddr[OFF_W-1:0],
                      s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache,
                      s_axi_arprot, s_axi_arqos};

endmodule

// File: tb/tb_axi_ddr_responder.sv
// Self-checking bench for axi_ddr_responder: directed cases plus randomized
// bursts checked against a word-indexed memory model.
module tb_axi_ddr_responder;

  localparam int unsigned DEPTH = 65536;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_axi_awid = 1'b0;
  logic [29:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic        s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic        s_axi_arid = 1'b0;
  logic [29:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic        s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  axi_ddr_responder #(.ADDR_W(30), .DATA_W(32), .MEM_ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(3'd2), .s_axi_awburst(2'd1), .s_axi_awlock(1'b0),
    .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awqos(4'd0),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(3'd2), .s_axi_arburst(2'd1), .s_axi_arlock(1'b0),
    .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arqos(4'd0),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference memory: word index -> 32-bit contents
  logic [31:0] mdl [int unsigned];
  logic [31:0] wr_data [256];
  logic [3:0]  wr_strb [256];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned word_of(input logic [29:0] a);
    return (int'(a) / 4) % DEPTH;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bad_beat >= 0 flips wlast on that beat; bhold cycles of bready low
  task automatic axi_write(input logic [29:0] addr, input int len, input logic id,
                           input int bad_beat, input int bhold);
    int n;
    int unsigned idx;
    logic [31:0] w;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 100) begin tick(); n++; end
    if (n >= 100) check("aw_timeout", 0, 1);
    tick();
    s_axi_awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      s_axi_wdata = wr_data[k]; s_axi_wstrb = wr_strb[k];
      s_axi_wlast = (k == len) ^ (k == bad_beat); s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 100) begin tick(); n++; end
      if (n >= 100) check("w_timeout", 0, 1);
      tick();
      idx = (word_of(addr) + k) % DEPTH;
      w = mdl.exists(idx) ? mdl[idx] : 32'h0;
      for (int b = 0; b < 4; b++) if (wr_strb[k][b]) w[8*b +: 8] = wr_data[k][8*b +: 8];
      mdl[idx] = w;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    for (int i = 0; i < bhold; i++) begin
      s_axi_awvalid = 1'b1;
      check("bvalid_hold", s_axi_bvalid, 1);
      check("aw_blocked", s_axi_awready, 0);
      tick();
    end
    s_axi_awvalid = 1'b0;
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 100) begin tick(); n++; end
    if (n >= 100) check("b_timeout", 0, 1);
    check("bresp", s_axi_bresp, (bad_beat >= 0) ? 2 : 0);
    check("bid", s_axi_bid, id);
    tick();
    s_axi_bready = 1'b0;
  endtask

  // rand_rr=1 toggles rready pseudo-randomly; expectations snapshot the model at call
  task automatic axi_read(input logic [29:0] addr, input int len, input logic id, input bit rand_rr);
    logic [31:0] exp_q[$];
    int unsigned idx;
    int n, lat, beat;
    for (int k = 0; k <= len; k++) begin
      idx = (word_of(addr) + k) % DEPTH;
      exp_q.push_back(mdl.exists(idx) ? mdl[idx] : 32'h0);
    end
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 100) begin tick(); n++; end
    if (n >= 100) check("ar_timeout", 0, 1);
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_rready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
    lat = 1;
    while (!s_axi_rvalid && lat < 20) begin tick(); lat++; end
    check("r_latency", lat, 2);
    beat = 0; n = 0;
    while (beat <= len && n < 5000) begin
      s_axi_rready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_axi_rvalid) begin
        check("rdata", s_axi_rdata, exp_q[beat]);
        check("rlast", s_axi_rlast, beat == len);
        check("rid", s_axi_rid, id);
        check("rresp", s_axi_rresp, 0);
        if (s_axi_rready) beat++;
      end else if (!rand_rr) begin
        check("r_continuous", s_axi_rvalid, 1);
      end
      tick();
      n++;
    end
    s_axi_rready = 1'b0;
    check("r_beats", beat, len + 1);
    check("r_idle_valid", s_axi_rvalid, 0);
    check("r_idle_arready", s_axi_arready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, beat, len, bb;
    logic stray;
    logic [29:0] a;

    // reset values
    repeat (3) tick();
    check("rst_awready", s_axi_awready, 1);
    check("rst_arready", s_axi_arready, 1);
    check("rst_wready", s_axi_wready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_rlast", s_axi_rlast, 0);
    check("rst_bresp", s_axi_bresp, 0);
    check("rst_rresp", s_axi_rresp, 0);
    check("rst_bid", s_axi_bid, 0);
    check("rst_rid", s_axi_rid, 0);
    check("rst_rdata", s_axi_rdata, 0);
    rst_n = 1'b1;
    tick();

    // single write then read, id echoed
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
    axi_write(30'h100, 0, 1'b1, -1, 0);
    axi_read(30'h100, 0, 1'b1, 1'b0);
    check("single_const", mdl[64], 32'hDEADBEEF);

    // 16-beat burst, full-rate read
    for (int i = 0; i < 16; i++) begin wr_data[i] = 32'(i); wr_strb[i] = 4'hF; end
    axi_write(30'h0, 15, 1'b0, -1, 0);
    axi_read(30'h0, 15, 1'b0, 1'b0);

    // byte strobes
    wr_data[0] = 32'hFFFFFFFF; wr_strb[0] = 4'hF;
    axi_write(30'h200, 0, 1'b0, -1, 0);
    wr_data[0] = 32'h00000000; wr_strb[0] = 4'h5;
    axi_write(30'h200, 0, 1'b1, -1, 0);
    check("strb_model", mdl[128], 32'hFF00FF00);
    axi_read(30'h200, 0, 1'b0, 1'b0);

    // wlast errors: early wlast on beat 2, missing wlast on final beat
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + 32'(i); wr_strb[i] = 4'hF; end
    axi_write(30'h300, 3, 1'b1, 1, 0);
    axi_write(30'h400, 3, 1'b0, 3, 0);
    axi_read(30'h300, 3, 1'b0, 1'b0);

    // wrap from last word to word 0, and address aliasing
    wr_data[0] = 32'h1111_2222; wr_data[1] = 32'h3333_4444;
    wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    axi_write(30'(32'((DEPTH - 1) * 4)), 1, 1'b0, -1, 0);
    axi_read(30'h0, 0, 1'b0, 1'b0);
    axi_read(30'h2000_0000 | 30'(32'((DEPTH - 1) * 4)), 1, 1'b1, 1'b0);

    // 256-beat burst wrapping inside the burst, bready held, random rready
    for (int i = 0; i < 256; i++) begin wr_data[i] = $urandom(); wr_strb[i] = 4'hF; end
    axi_write(30'(32'((DEPTH - 100) * 4)), 255, 1'b1, -1, 10);
    axi_read(30'(32'((DEPTH - 100) * 4)), 255, 1'b1, 1'b1);

    // same-word read and write in the same cycles: read sees old data
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h5000 + 32'(i); wr_strb[i] = 4'hF; end
    axi_write(30'h800, 3, 1'b0, -1, 0);
    for (int i = 0; i < 4; i++) wr_data[i] = 32'h9000 + 32'(i);
    fork
      axi_write(30'h800, 3, 1'b1, -1, 0);
      axi_read(30'h800, 3, 1'b0, 1'b0);
    join
    axi_read(30'h800, 3, 1'b1, 1'b0);

    // reset during beat 3 of an 8-beat read
    for (int i = 0; i < 8; i++) begin wr_data[i] = 32'hC0DE0000 + 32'(i); wr_strb[i] = 4'hF; end
    axi_write(30'h4000, 7, 1'b0, -1, 0);
    s_axi_araddr = 30'h4000; s_axi_arlen = 8'd7; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 100) begin tick(); n++; end
    tick();
    s_axi_arvalid = 1'b0;
    beat = 0; n = 0;
    while (beat < 2 && n < 50) begin if (s_axi_rvalid) beat++; tick(); n++; end
    n = 0;
    while (!s_axi_rvalid && n < 50) begin tick(); n++; end
    check("mid_beat3_valid", s_axi_rvalid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", s_axi_rvalid, 0);
    check("mid_rst_rlast", s_axi_rlast, 0);
    check("mid_rst_arready", s_axi_arready, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    s_axi_bready = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stray = stray | s_axi_rvalid | s_axi_bvalid;
      tick();
    end
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    check("mid_rst_stray", stray, 0);
    check("mid_rst_arready_rel", s_axi_arready, 1);
    axi_read(30'h4000, 1, 1'b1, 1'b0);

    // randomized write / partial-strobe overwrite / read back
    for (int it = 0; it < 15; it++) begin
      a = 30'($urandom());
      len = $urandom_range(0, 31);
      for (int i = 0; i <= len; i++) begin wr_data[i] = $urandom(); wr_strb[i] = 4'hF; end
      axi_write(a, len, 1'($urandom_range(0, 1)), -1, $urandom_range(0, 3));
      for (int i = 0; i <= len; i++) begin wr_data[i] = $urandom(); wr_strb[i] = 4'($urandom()); end
      bb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      axi_write(a, len, 1'($urandom_range(0, 1)), bb, $urandom_range(0, 3));
      axi_read(a, len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
